// File: rtl/hf_tans_recoder_stream.sv
// Streaming recoder: decodes truncated-unary Huffman beats one symbol per cycle
// and re-encodes each symbol with a ranged-spread tANS table built from FREQ.
module hf_tans_recoder_stream #(
  parameter int unsigned IN_W = 2,
  parameter int unsigned NSYM = 3,
  parameter int unsigned R    = 3,
  parameter logic [NSYM*(R+1)-1:0] FREQ = {4'd2, 4'd2, 4'd4}
) (
  input  logic                        PHI,
  input  logic                        RST,
  input  logic                        I_VALID,
  output logic                        I_READY,
  input  logic [IN_W-1:0]             I_DATA,
  input  logic                        I_LAST,
  input  logic [$clog2(IN_W+1)-1:0]   I_NB,
  output logic                        O_VALID,
  input  logic                        O_READY,
  output logic [$clog2(R+1)-1:0]      O_NB,
  output logic [R-1:0]                O_BITS,
  output logic                        O_FINAL,
  output logic [R:0]                  O_STATE,
  output logic                        ERR
);

  localparam int unsigned XW   = R + 1;
  localparam int unsigned L    = 1 << R;
  localparam int unsigned BUFW = 2 * IN_W + NSYM - 2;
  localparam int unsigned CW   = $clog2(BUFW + 1);
  localparam int unsigned NBIW = $clog2(IN_W + 1);
  localparam int unsigned ONW  = $clog2(R + 1);
  localparam int unsigned SW   = $clog2(NSYM);

  function automatic int unsigned freq_of(input int unsigned s);
    return 32'(FREQ[s*XW +: XW]);
  endfunction

  function automatic int unsigned cum_of(input int unsigned s);
    int unsigned acc;
    acc = 0;
    for (int unsigned j = 0; j < s; j++) acc += freq_of(j);
    return acc;
  endfunction

  function automatic bit freq_ok();
    int unsigned sum;
    sum = 0;
    for (int unsigned j = 0; j < NSYM; j++) begin
      if (freq_of(j) == 0) return 1'b0;
      sum += freq_of(j);
    end
    return sum == L;
  endfunction

  if (!freq_ok()) begin : g_freq_err
    $error("FREQ entries must all be >= 1 and sum to 2**R");
  end

  logic [BUFW-1:0] buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_seen_q, last_seen_d;
  logic [XW-1:0]   x_q, x_d;
  logic            o_valid_q, o_valid_d;
  logic [ONW-1:0]  o_nb_q, o_nb_d;
  logic [R-1:0]    o_bits_q, o_bits_d;
  logic            o_final_q, o_final_d;
  logic [XW-1:0]   o_state_q, o_state_d;
  logic            err_q, err_d;

  logic            found, decodable;
  logic [SW-1:0]   k, sym;
  logic [CW-1:0]   pop_len;
  logic [XW-1:0]   fs, cs, mask, x_next;
  logic [ONW-1:0]  enc_nb;
  logic [R-1:0]    enc_bits;

  // Head-of-buffer codeword: first zero within NSYM-1 valid bits, else all-ones symbol.
  always_comb begin
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NSYM - 1; i++) begin
      if (!found && CW'(i) < cnt_q && !buf_q[i]) begin
        found = 1'b1;
        k     = SW'(i);
      end
    end
    decodable = found || (cnt_q >= CW'(NSYM - 1));
    sym       = found ? k : SW'(NSYM - 1);
    pop_len   = found ? CW'(k) + CW'(1) : CW'(NSYM - 1);
  end

  // tANS step: smallest shift bringing x below 2*f_s, then x' = L + c_s + (x>>nb) - f_s.
  always_comb begin
    fs = '0;
    cs = '0;
    for (int unsigned s = 0; s < NSYM; s++) begin
      if (SW'(s) == sym) begin
        fs = XW'(freq_of(s));
        cs = XW'(cum_of(s));
      end
    end
    enc_nb = ONW'(R);
    for (int n = int'(R); n >= 0; n--) begin
      if ({1'b0, x_q >> n} < {fs, 1'b0}) enc_nb = ONW'(n);
    end
    mask     = (XW'(1) << enc_nb) - XW'(1);
    enc_bits = R'(x_q & mask);
    x_next   = XW'(L) + cs + (x_q >> enc_nb) - fs;
  end

  logic            out_free, accept, fin_busy, do_pop;
  logic [NBIW-1:0] nb_in;
  logic [IN_W-1:0] in_bits;
  logic [CW-1:0]   rem_cnt;
  logic [BUFW-1:0] rem_buf;

  assign I_READY = !RST && (cnt_q <= CW'(BUFW - IN_W)) && !last_seen_q;

  always_comb begin
    out_free    = !o_valid_q || O_READY;
    accept      = I_VALID && I_READY;
    fin_busy    = o_valid_q && o_final_q;
    nb_in       = I_LAST ? I_NB : NBIW'(IN_W);
    in_bits     = I_DATA & ~({IN_W{1'b1}} << nb_in);
    do_pop      = 1'b0;
    x_d         = x_q;
    last_seen_d = last_seen_q;
    o_valid_d   = o_valid_q;
    o_nb_d      = o_nb_q;
    o_bits_d    = o_bits_q;
    o_final_d   = o_final_q;
    o_state_d   = o_state_q;
    err_d       = 1'b0;

    if (out_free) begin
      o_valid_d = 1'b0;
      o_nb_d    = '0;
      o_bits_d  = '0;
      o_final_d = 1'b0;
      o_state_d = '0;
    end
    if (fin_busy && O_READY) begin
      x_d         = XW'(L);
      last_seen_d = 1'b0;
    end

    if (cnt_q != '0 && decodable) begin
      if (out_free) begin
        do_pop    = 1'b1;
        o_valid_d = 1'b1;
        o_nb_d    = enc_nb;
        o_bits_d  = enc_bits;
        x_d       = x_next;
      end
    end else if (last_seen_q && cnt_q != '0) begin
      err_d = 1'b1;
    end else if (last_seen_q && out_free && !fin_busy) begin
      o_valid_d = 1'b1;
      o_final_d = 1'b1;
      o_state_d = x_q;
    end

    rem_cnt = do_pop ? cnt_q - pop_len : cnt_q;
    rem_buf = do_pop ? buf_q >> pop_len : buf_q;
    cnt_d   = rem_cnt;
    buf_d   = rem_buf;
    if (accept) begin
      buf_d = rem_buf | (BUFW'(in_bits) << rem_cnt);
      cnt_d = rem_cnt + CW'(nb_in);
      if (I_LAST) last_seen_d = 1'b1;
    end
    // Truncated trailing codeword is dropped so the block can still close.
    if (err_d) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge PHI or posedge RST) begin
    if (RST) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      x_q         <= XW'(L);
      o_valid_q   <= 1'b0;
      o_nb_q      <= '0;
      o_bits_q    <= '0;
      o_final_q   <= 1'b0;
      o_state_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      x_q         <= x_d;
      o_valid_q   <= o_valid_d;
      o_nb_q      <= o_nb_d;
      o_bits_q    <= o_bits_d;
      o_final_q   <= o_final_d;
      o_state_q   <= o_state_d;
      err_q       <= err_d;
    end
  end

  assign O_VALID = o_valid_q;
  assign O_NB    = o_nb_q;
  assign O_BITS  = o_bits_q;
  assign O_FINAL = o_final_q;
  assign O_STATE = o_state_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_hf_tans_recoder_stream.sv
// Scoreboard bench for hf_tans_recoder_stream with default parameters
// (IN_W=2, NSYM=3, R=3, f = {4,2,2}).
module tb_hf_tans_recoder_stream;

  logic       PHI = 1'b0;
  logic       RST = 1'b1;
  logic       I_VALID = 1'b0;
  logic       I_READY;
  logic [1:0] I_DATA = '0;
  logic       I_LAST = 1'b0;
  logic [1:0] I_NB = '0;
  logic       O_VALID;
  logic       O_READY = 1'b1;
  logic [1:0] O_NB;
  logic [2:0] O_BITS;
  logic       O_FINAL;
  logic [3:0] O_STATE;
  logic       ERR;

  hf_tans_recoder_stream #(
    .IN_W(2), .NSYM(3), .R(3), .FREQ({4'd2, 4'd2, 4'd4})
  ) dut (
    .PHI(PHI), .RST(RST),
    .I_VALID(I_VALID), .I_READY(I_READY), .I_DATA(I_DATA), .I_LAST(I_LAST), .I_NB(I_NB),
    .O_VALID(O_VALID), .O_READY(O_READY), .O_NB(O_NB), .O_BITS(O_BITS),
    .O_FINAL(O_FINAL), .O_STATE(O_STATE), .ERR(ERR)
  );

  always #5 PHI = ~PHI;

  typedef struct packed {
    logic       fin;
    logic [1:0] nb;
    logic [2:0] bits;
    logic [3:0] st;
  } beat_t;

  beat_t      exp_q[$];
  logic [1:0] beat_q[$];
  int         last_nb;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_seen = 0;
  int         tx = 8;
  beat_t      mon_e;

  // Scoreboard: every consumed output beat is popped and compared.
  always @(negedge PHI) begin
    if (!RST) begin
      if (ERR) err_seen++;
      if (O_VALID && O_READY) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat got fin=%0b nb=%0d bits=%b state=%0d, want no beat",
                   O_FINAL, O_NB, O_BITS, O_STATE);
        end else begin
          mon_e = exp_q.pop_front();
          if ({O_FINAL, O_NB, O_BITS, O_STATE} !== mon_e) begin
            n_bad++;
            $display("FAIL beat got fin=%0b nb=%0d bits=%b state=%0d, want fin=%0b nb=%0d bits=%b state=%0d",
                     O_FINAL, O_NB, O_BITS, O_STATE, mon_e.fin, mon_e.nb, mon_e.bits, mon_e.st);
          end
        end
      end
    end
  end

  task automatic push_beat(input logic fin, input logic [1:0] nb, input logic [2:0] bits,
                           input logic [3:0] st);
    exp_q.push_back({fin, nb, bits, st});
  endtask

  // Reference tANS step for f={4,2,2}, c={0,4,6}, L=8.
  task automatic push_sym(input int s);
    int f, c, n;
    f = (s == 0) ? 4 : 2;
    c = (s == 0) ? 0 : ((s == 1) ? 4 : 6);
    n = 0;
    while ((tx >> n) >= 2 * f) n++;
    push_beat(1'b0, 2'(n), 3'(tx & ((1 << n) - 1)), 4'd0);
    tx = 8 + c + (tx >> n) - f;
  endtask

  task automatic push_final();
    push_beat(1'b1, 2'd0, 3'd0, 4'(tx));
    tx = 8;
  endtask

  task automatic send_stream(input bit with_last, output bit ok);
    bit rdy;
    int t;
    ok = 1'b1;
    for (int i = 0; i < beat_q.size(); i++) begin
      I_VALID = 1'b1;
      I_DATA  = beat_q[i];
      I_LAST  = with_last && (i == beat_q.size() - 1);
      I_NB    = I_LAST ? 2'(last_nb) : 2'd2;
      rdy = 1'b0;
      t = 0;
      while (!rdy && t < 300) begin
        @(negedge PHI);
        rdy = I_READY;
        @(posedge PHI);
        #1;
        t++;
      end
      if (!rdy) begin
        ok = 1'b0;
        break;
      end
    end
    I_VALID = 1'b0;
    I_LAST  = 1'b0;
    I_NB    = '0;
    I_DATA  = '0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int t = 0; t < max_cyc && exp_q.size() != 0; t++) @(posedge PHI);
    repeat (4) @(posedge PHI);
    #1;
  endtask

  task automatic test_reset();
    @(negedge PHI);
    n_cmp += 7;
    if (I_READY !== 1'b0) begin n_bad++; $display("FAIL reset_i_ready got %b want 0", I_READY); end
    if (O_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid got %b want 0", O_VALID); end
    if (O_NB !== 2'd0) begin n_bad++; $display("FAIL reset_o_nb got %0d want 0", O_NB); end
    if (O_BITS !== 3'd0) begin n_bad++; $display("FAIL reset_o_bits got %b want 000", O_BITS); end
    if (O_FINAL !== 1'b0) begin n_bad++; $display("FAIL reset_o_final got %b want 0", O_FINAL); end
    if (O_STATE !== 4'd0) begin n_bad++; $display("FAIL reset_o_state got %0d want 0", O_STATE); end
    if (ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", ERR); end
    @(posedge PHI);
    #1 RST = 1'b0;
    @(negedge PHI);
    n_cmp++;
    if (I_READY !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got %b want 1", I_READY); end
    @(posedge PHI);
    #1;
  endtask

  // One beat 2'b00 (last) -> A A; first symbol beat visible after the second edge.
  task automatic test_latency();
    push_sym(0);
    push_sym(0);
    push_final();
    I_VALID = 1'b1; I_DATA = 2'b00; I_LAST = 1'b1; I_NB = 2'd2;
    @(negedge PHI);
    n_cmp++;
    if (I_READY !== 1'b1) begin n_bad++; $display("FAIL lat_ready got %b want 1", I_READY); end
    @(posedge PHI);
    #1;
    I_VALID = 1'b0; I_LAST = 1'b0; I_NB = '0;
    @(negedge PHI);
    n_cmp++;
    if (O_VALID !== 1'b0) begin n_bad++; $display("FAIL lat_early got %b want 0", O_VALID); end
    @(negedge PHI);
    n_cmp++;
    if (O_VALID !== 1'b1) begin n_bad++; $display("FAIL lat_first got %b want 1", O_VALID); end
    wait_drain(100);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL lat_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_basic();
    int e0;
    bit ok;
    e0 = err_seen;
    push_beat(1'b0, 2'd1, 3'b000, 4'd0);
    push_beat(1'b0, 2'd2, 3'b000, 4'd0);
    push_beat(1'b0, 2'd2, 3'b010, 4'd0);
    push_beat(1'b0, 2'd1, 3'b001, 4'd0);
    push_beat(1'b1, 2'd0, 3'b000, 4'b1010);
    beat_q.delete();
    beat_q.push_back(2'b10); beat_q.push_back(2'b11); beat_q.push_back(2'b00);
    last_nb = 2;
    send_stream(1'b1, ok);
    wait_drain(100);
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL basic_send timeout got 0 want 1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL basic_drain left %0d want 0", exp_q.size()); end
    if (err_seen != e0) begin n_bad++; $display("FAIL basic_err got %0d want 0", err_seen - e0); end
  endtask

  task automatic test_all_a();
    bit ok;
    for (int i = 0; i < 16; i++) push_beat(1'b0, 2'd1, 3'b000, 4'd0);
    push_beat(1'b1, 2'd0, 3'b000, 4'd8);
    beat_q.delete();
    for (int i = 0; i < 8; i++) beat_q.push_back(2'b00);
    last_nb = 2;
    send_stream(1'b1, ok);
    wait_drain(200);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL all_a_send timeout got 0 want 1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL all_a_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_all_c();
    bit ok;
    push_beat(1'b0, 2'd2, 3'b000, 4'd0);
    push_beat(1'b0, 2'd2, 3'b010, 4'd0);
    for (int i = 0; i < 14; i++) push_beat(1'b0, 2'd2, 3'b011, 4'd0);
    push_beat(1'b1, 2'd0, 3'b000, 4'd15);
    beat_q.delete();
    for (int i = 0; i < 16; i++) beat_q.push_back(2'b11);
    last_nb = 2;
    send_stream(1'b1, ok);
    wait_drain(200);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL all_c_send timeout got 0 want 1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL all_c_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_err();
    int e0;
    bit ok;
    e0 = err_seen;
    push_beat(1'b1, 2'd0, 3'b000, 4'd8);
    beat_q.delete();
    beat_q.push_back(2'b01);
    last_nb = 1;
    send_stream(1'b1, ok);
    wait_drain(100);
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL err_send timeout got 0 want 1"); end
    if (err_seen - e0 != 1) begin n_bad++; $display("FAIL err_pulses got %0d want 1", err_seen - e0); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL err_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int bitq[$];
    int total, t, s;
    bit ok;
    for (int i = 0; i < 24; i++) begin
      s = int'($urandom_range(0, 2));
      push_sym(s);
      for (int j = 0; j < s; j++) bitq.push_back(1);
      if (s < 2) bitq.push_back(0);
    end
    push_final();
    total = exp_q.size();
    beat_q.delete();
    while (bitq.size() > 0) begin
      if (bitq.size() >= 2) begin
        beat_q.push_back({1'(bitq[1]), 1'(bitq[0])});
        last_nb = 2;
        void'(bitq.pop_front());
        void'(bitq.pop_front());
      end else begin
        beat_q.push_back({1'b0, 1'(bitq[0])});
        last_nb = 1;
        void'(bitq.pop_front());
      end
    end
    fork
      send_stream(1'b1, ok);
      begin
        t = 0;
        while (exp_q.size() > total - 3 && t < 300) begin
          @(posedge PHI);
          t++;
        end
        @(posedge PHI);
        #1 O_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge PHI);
          if (i >= 3) begin
            n_cmp++;
            if (O_VALID !== 1'b1 || exp_q.size() == 0 ||
                {O_NB, O_BITS} !== {exp_q[0].nb, exp_q[0].bits}) begin
              n_bad++;
              $display("FAIL stall_hold cyc=%0d got v=%b nb=%0d bits=%b want v=1 nb=%0d bits=%b",
                       i, O_VALID, O_NB, O_BITS, exp_q[0].nb, exp_q[0].bits);
            end
          end
        end
        n_cmp++;
        if (I_READY !== 1'b0) begin n_bad++; $display("FAIL stall_ready got %b want 0", I_READY); end
        @(posedge PHI);
        #1 O_READY = 1'b1;
      end
    join
    wait_drain(300);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL bp_send timeout got 0 want 1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_drain left %0d want 0", exp_q.size()); end
  endtask

  // Partial block (A C + one dangling bit), then reset; the block is lost silently.
  task automatic test_reset_mid();
    bit ok;
    push_beat(1'b0, 2'd1, 3'b000, 4'd0);
    push_beat(1'b0, 2'd2, 3'b000, 4'd0);
    beat_q.delete();
    beat_q.push_back(2'b10); beat_q.push_back(2'b11);
    last_nb = 2;
    send_stream(1'b0, ok);
    wait_drain(100);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL rmid_send timeout got 0 want 1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rmid_drain left %0d want 0", exp_q.size()); end
    @(posedge PHI);
    #1 RST = 1'b1;
    @(negedge PHI);
    n_cmp += 2;
    if (I_READY !== 1'b0) begin n_bad++; $display("FAIL rmid_ready got %b want 0", I_READY); end
    if (O_VALID !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", O_VALID); end
    @(posedge PHI);
    #1 RST = 1'b0;
    tx = 8;
    repeat (3) @(posedge PHI);
    #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_all_a();
    test_all_c();
    test_err();
    test_backpressure();
    test_reset_mid();
    test_basic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
